// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I multicycle controller: FSM states, opcodes,
// ALU operation codes and datapath select values.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_ERROR
    } state_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    function automatic logic [1:0] imm_fmt(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields, flags and memory ready in,
// mux selects, strobes and ALU control out.
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       negative;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] imm_src;
    logic [1:0] result_src;
    logic       trap;

    modport master (
        input  op, funct3, funct7b5, zero, negative, mem_ready,
        output pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
               alu_src_a, alu_src_b, alu_control, imm_src, result_src, trap
    );

    modport slave (
        output op, funct3, funct7b5, zero, negative, mem_ready,
        input  pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
               alu_src_a, alu_src_b, alu_control, imm_src, result_src, trap
    );
endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU control decode; flags funct3 values the ALU cannot execute.
module alu_decoder
    import ctrl_pkg::*;
(
    input  aluop_e     alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       op5_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_control_o,
    output logic       illegal_o
);
    always_comb begin
        alu_control_o = ALU_ADD;
        illegal_o     = 1'b0;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            default: begin
                case (funct3_i)
                    3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: illegal_o = 1'b1;
                endcase
            end
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// RV32I multicycle control FSM: R/I/sw/jal 4 cycles, lw 5, branch 3; stalls in memory states until
// mem_ready, traps after MEM_TIMEOUT idle cycles. CTRL_PERF_CNT_EN adds cycle/instret counters.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rstn,
    multicycle_ctrl_if.master bus
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       instret_cnt
`endif
);
    localparam logic [31:0] WD_LIMIT = 32'(MEM_TIMEOUT);

    state_e      state_q, state_d;
    logic        trap_q;
    logic [31:0] wd_q, wd_d;
    aluop_e      alu_op;
    logic [2:0]  alu_ctl;
    logic        alu_illegal, taken, mem_wait, timeout;
    logic        pc_write_raw, ir_write_raw, mem_read_raw, mem_write_raw, reg_write_raw;

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct3_i      (bus.funct3),
        .op5_i         (bus.op[5]),
        .funct7b5_i    (bus.funct7b5),
        .alu_control_o (alu_ctl),
        .illegal_o     (alu_illegal)
    );

    always_comb begin
        case (bus.funct3)
            3'b000:  taken = bus.zero;
            3'b001:  taken = !bus.zero;
            3'b100:  taken = bus.negative;
            3'b101:  taken = !bus.negative;
            default: taken = 1'b0;
        endcase
    end

    // A ready in the limit cycle still completes the access normally.
    assign mem_wait = (state_q inside {S_FETCH, S_MEMREAD, S_MEMWRITE}) && !bus.mem_ready;
    assign timeout  = (MEM_TIMEOUT > 0) && mem_wait && ((wd_q + 32'd1) == WD_LIMIT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE; else if (timeout) state_d = S_ERROR;
            S_DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_ERROR;
                endcase
            end
            S_MEMADR:   state_d = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB; else if (timeout) state_d = S_ERROR;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH; else if (timeout) state_d = S_ERROR;
            S_EXECR, S_EXECI: state_d = alu_illegal ? S_ERROR : S_ALUWB;
            S_ALUWB, S_BRANCH: state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_ERROR;
        endcase
        wd_d = (mem_wait && (state_d == state_q)) ? wd_q + 32'd1 : 32'd0;
    end

    always_comb begin
        pc_write_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        mem_read_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        bus.adr_src    = 1'b0;
        bus.alu_src_a  = SRCA_PC;
        bus.alu_src_b  = SRCB_RS2;
        bus.result_src = RES_ALUOUT;
        alu_op         = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                mem_read_raw   = 1'b1;
                bus.alu_src_b  = SRCB_FOUR;
                bus.result_src = RES_ALU;
                ir_write_raw   = bus.mem_ready;
                pc_write_raw   = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                bus.adr_src  = 1'b1;
                mem_read_raw = 1'b1;
            end
            S_MEMWB: begin
                bus.result_src = RES_MEM;
                reg_write_raw  = 1'b1;
            end
            S_MEMWRITE: begin
                bus.adr_src   = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECR: begin
                bus.alu_src_a = SRCA_RS1;
                alu_op        = ALUOP_FUNCT;
            end
            S_EXECI: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
                alu_op        = ALUOP_FUNCT;
            end
            S_ALUWB: reg_write_raw = 1'b1;
            S_BRANCH: begin
                bus.alu_src_a = SRCA_RS1;
                alu_op        = ALUOP_SUB;
                pc_write_raw  = taken;
            end
            S_JAL: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_FOUR;
                pc_write_raw  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.pc_write    = pc_write_raw  & rstn;
    assign bus.ir_write    = ir_write_raw  & rstn;
    assign bus.mem_read    = mem_read_raw  & rstn;
    assign bus.mem_write   = mem_write_raw & rstn;
    assign bus.reg_write   = reg_write_raw & rstn;
    assign bus.alu_control = alu_ctl;
    assign bus.imm_src     = imm_fmt(bus.op);
    assign bus.trap        = trap_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_FETCH;
            trap_q  <= 1'b0;
            wd_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            if (state_d == S_ERROR) trap_q <= 1'b1;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_q, instret_q;
    logic        retire;

    assign retire = (state_d == S_FETCH) &&
                    (state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH});

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cycle_q   <= 32'd0;
            instret_q <= 32'd0;
        end else begin
            if (state_q != S_ERROR) cycle_q <= cycle_q + 32'd1;
            if (retire) instret_q <= instret_q + 32'd1;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed latency table, hand-written corner sequences,
// and random instruction streams checked per cycle against a per-instruction phase model.
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
`ifdef CTRL_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    typedef struct packed {
        logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
        logic [1:0] src_a, src_b;
        logic [2:0] alu;
        logic [1:0] imm, res;
        logic       trap;
    } out_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7, z, n;
        int         fw, mw, cyc, rw, pcw;
        logic       trap;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int icount = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic out_t sample();
        out_t o;
        o.pc_write = bus.pc_write;  o.ir_write = bus.ir_write;  o.adr_src = bus.adr_src;
        o.mem_read = bus.mem_read;  o.mem_write = bus.mem_write; o.reg_write = bus.reg_write;
        o.src_a = bus.alu_src_a;    o.src_b = bus.alu_src_b;    o.alu = bus.alu_control;
        o.imm = bus.imm_src;        o.res = bus.result_src;     o.trap = bus.trap;
        return o;
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] op);
        if (op == 7'b0100011) return 2'b01;
        if (op == 7'b1100011) return 2'b10;
        if (op == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    // Expected output image of each instruction phase
    function automatic out_t ph(input int p, input logic flag, input logic [2:0] alu);
        out_t o;
        o = '0;
        case (p)
            0: begin o.mem_read = 1'b1; o.src_b = 2'b10; o.res = 2'b10; o.pc_write = flag; o.ir_write = flag; end
            1: begin o.src_a = 2'b01; o.src_b = 2'b01; end
            2: begin o.src_a = 2'b10; o.src_b = 2'b01; end
            3: begin o.adr_src = 1'b1; o.mem_read = 1'b1; end
            4: begin o.res = 2'b01; o.reg_write = 1'b1; end
            5: begin o.adr_src = 1'b1; o.mem_write = 1'b1; end
            6: begin o.src_a = 2'b10; o.src_b = flag ? 2'b01 : 2'b00; o.alu = alu; end
            7: o.reg_write = 1'b1;
            8: begin o.src_a = 2'b10; o.alu = 3'b001; o.pc_write = flag; end
            9: begin o.src_a = 2'b01; o.src_b = 2'b10; o.pc_write = 1'b1; end
            default: o.trap = 1'b1;
        endcase
        return o;
    endfunction

    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5,
                   EXEC = 6, ALUWB = 7, BRANCH = 8, JAL = 9, ERR = 10;

    task automatic step(input logic rdy, input out_t e, input string nm);
        @(negedge clk);
        bus.mem_ready = rdy;
        #1;
        e.imm = exp_imm(bus.op);
        check(nm, 32'(sample()), 32'(e));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        check("reset_strobes", {27'd0, bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write}, 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        icount = 0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc = 0, rw = 0, pcw = 0, fcnt = 0, mcnt = 0;
        logic other = 1'b0, tr = 1'b0, done = 1'b0, is_fetch;
        bus.op = v.op; bus.funct3 = v.f3; bus.funct7b5 = v.f7; bus.zero = v.z; bus.negative = v.n;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            is_fetch = bus.mem_read && !bus.adr_src;
            if (is_fetch) begin bus.mem_ready = (fcnt >= v.fw); fcnt++; end
            else if (bus.adr_src && (bus.mem_read || bus.mem_write)) begin bus.mem_ready = (mcnt >= v.mw); mcnt++; end
            else bus.mem_ready = 1'b0;
            #1;
            if (bus.trap) begin tr = 1'b1; cyc++; done = 1'b1; end
            else if (is_fetch && other) done = 1'b1;
            else begin
                if (!is_fetch) other = 1'b1;
                cyc++;
                rw  += int'(bus.reg_write);
                pcw += int'(bus.pc_write);
            end
        end
        check($sformatf("vec%0d_done", idx), 32'(done), 32'd1);
        check($sformatf("vec%0d_cycles", idx), cyc, v.cyc);
        check($sformatf("vec%0d_regwr", idx), rw, v.rw);
        check($sformatf("vec%0d_pcwr", idx), pcw, v.pcw);
        check($sformatf("vec%0d_trap", idx), 32'(tr), 32'(v.trap));
        do_reset();
    endtask

    task automatic fetch_phase(input int w);
        for (int i = 0; i < w; i++) step(1'b0, ph(FETCH, 1'b0, 3'd0), "fetch_wait");
        step(1'b1, ph(FETCH, 1'b1, 3'd0), "fetch");
    endtask

    function automatic logic legal_op(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    endfunction

    task automatic rnd_instr();
        int k;
        logic [6:0] op;
        logic [2:0] f3, alu;
        logic tk, bad;
        k = $urandom_range(0, 9);
        bus.zero = 1'($urandom); bus.negative = 1'($urandom); bus.funct7b5 = 1'($urandom);
        f3 = 3'($urandom);
        case (k)
            0, 1: op = 7'b0110011;
            2, 3: op = 7'b0010011;
            4: op = 7'b0000011;
            5: op = 7'b0100011;
            6, 7: op = 7'b1100011;
            8: op = 7'b1101111;
            default: begin
                op = 7'($urandom);
                while (legal_op(op)) op = 7'($urandom);
            end
        endcase
        bus.op = op; bus.funct3 = f3;
        fetch_phase($urandom_range(0, 3));
        step(1'($urandom), ph(DECODE, 1'b0, 3'd0), "decode");
        if (k <= 3) begin
            bad = 1'b0;
            alu = 3'b000;
            if (f3 == 3'b000) alu = (op == 7'b0110011 && bus.funct7b5) ? 3'b001 : 3'b000;
            else if (f3 == 3'b010) alu = 3'b101;
            else if (f3 == 3'b110) alu = 3'b011;
            else if (f3 == 3'b111) alu = 3'b010;
            else bad = 1'b1;
            step(1'($urandom), ph(EXEC, k >= 2, alu), "exec");
            if (bad) begin
                step(1'($urandom), ph(ERR, 1'b0, 3'd0), "alu_illegal_err");
                do_reset();
            end else begin
                step(1'($urandom), ph(ALUWB, 1'b0, 3'd0), "aluwb");
                icount++;
            end
        end else if (k == 4 || k == 5) begin
            step(1'($urandom), ph(MEMADR, 1'b0, 3'd0), "memadr");
            for (int i = $urandom_range(0, 3); i > 0; i--)
                step(1'b0, ph(k == 4 ? MEMRD : MEMWR, 1'b0, 3'd0), "mem_wait");
            step(1'b1, ph(k == 4 ? MEMRD : MEMWR, 1'b0, 3'd0), "mem_done");
            if (k == 4) step(1'($urandom), ph(MEMWB, 1'b0, 3'd0), "memwb");
            icount++;
        end else if (k <= 7) begin
            case (f3)
                3'b000: tk = bus.zero;
                3'b001: tk = !bus.zero;
                3'b100: tk = bus.negative;
                3'b101: tk = !bus.negative;
                default: tk = 1'b0;
            endcase
            step(1'($urandom), ph(BRANCH, tk, 3'd0), "branch");
            icount++;
        end else if (k == 8) begin
            step(1'($urandom), ph(JAL, 1'b0, 3'd0), "jal");
            step(1'($urandom), ph(ALUWB, 1'b0, 3'd0), "jal_wb");
            icount++;
        end else begin
            step(1'($urandom), ph(ERR, 1'b0, 3'd0), "illegal_err");
            step(1'($urandom), ph(ERR, 1'b0, 3'd0), "illegal_sticky");
            do_reset();
        end
    endtask

    vec_t tbl[16];

    initial begin
        // op, f3, f7, zero, neg, fetch waits, mem waits, cycles, reg writes, pc writes, trap
        tbl[0]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 4, 1, 1, 1'b0};
        tbl[1]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0, 4, 1, 1, 1'b0};
        tbl[2]  = '{7'b0010011, 3'b111, 1'b0, 1'b0, 1'b0, 0, 0, 4, 1, 1, 1'b0};
        tbl[3]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 0, 3, 8, 1, 1, 1'b0};
        tbl[4]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 1, 1'b0};
        tbl[5]  = '{7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 0, 0, 3, 0, 2, 1'b0};
        tbl[6]  = '{7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 3, 0, 1, 1'b0};
        tbl[7]  = '{7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1, 0, 0, 3, 0, 2, 1'b0};
        tbl[8]  = '{7'b1100011, 3'b101, 1'b0, 1'b0, 1'b1, 0, 0, 3, 0, 1, 1'b0};
        tbl[9]  = '{7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 4, 1, 2, 1'b0};
        tbl[10] = '{7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 3, 0, 1, 1'b1};
        tbl[11] = '{7'b0110011, 3'b001, 1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 1, 1'b1};
        tbl[12] = '{7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 99, 0, 17, 0, 0, 1'b1};
        tbl[13] = '{7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 15, 0, 19, 1, 1, 1'b0};
        tbl[14] = '{7'b0000011, 3'b000, 1'b0, 1'b0, 1'b0, 2, 15, 22, 1, 1, 1'b0};
        tbl[15] = '{7'b1100011, 3'b010, 1'b0, 1'b1, 1'b1, 0, 0, 3, 0, 1, 1'b0};

        bus.op = 7'b0110011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0;
        bus.zero = 1'b0; bus.negative = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        step(1'b0, ph(FETCH, 1'b0, 3'd0), "reset_state");

        for (int i = 0; i < 16; i++) run_vec(tbl[i], i);

        // Reset while a store waits in MEMWRITE
        bus.op = 7'b0100011; bus.funct3 = 3'b010;
        fetch_phase(0);
        step(1'b0, ph(DECODE, 1'b0, 3'd0), "sw_decode");
        step(1'b0, ph(MEMADR, 1'b0, 3'd0), "sw_memadr");
        step(1'b0, ph(MEMWR, 1'b0, 3'd0), "sw_memwrite");
        @(negedge clk);
        rstn = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        check("rst_memwrite_strobe", 32'(bus.mem_write), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        step(1'b0, ph(FETCH, 1'b0, 3'd0), "rst_memwrite_fetch");
`ifdef CTRL_PERF_CNT_EN
        check("rst_cycle_cnt", cycle_cnt, 32'd0);
        check("rst_instret_cnt", instret_cnt, 32'd0);
`endif

        // Illegal opcode: trap is sticky and strobes stay low until reset
        bus.op = 7'b0000000;
        fetch_phase(0);
        step(1'b1, ph(DECODE, 1'b0, 3'd0), "ill_decode");
        for (int i = 0; i < 4; i++) step(1'(i), ph(ERR, 1'b0, 3'd0), "ill_error_hold");
        do_reset();
        step(1'b0, ph(FETCH, 1'b0, 3'd0), "ill_after_reset");

        do_reset();
        for (int i = 0; i < 300; i++) rnd_instr();
`ifdef CTRL_PERF_CNT_EN
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        check("instret_model", instret_cnt, icount);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle control FSM for the RV32I core datapath: PC, instruction/data memory, register file, immediate generator, ALU and result muxes.
- Sequences each instruction through fetch/decode/execute/memory/writeback.
- Drives all mux selects, write enables and ALU control.
- Waits on a memory-ready handshake.
- Traps on illegal opcodes or a memory timeout.

Parameters:
MEM_TIMEOUT, 16, max cycles waiting on mem_ready before trap; 0 disables watchdog

Ports:
clk  in  1  core clock
rstn  in  1  synchronous active-low reset
op  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7b5  in  1  IR[30]
zero  in  1  ALU zero flag
negative  in  1  ALU negative flag
mem_ready  in  1  memory access completes this cycle
pc_write  out  1  PC load strobe
ir_write  out  1  IR/oldPC load strobe
adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg_write  out  1  register file write strobe
alu_src_a  out  2  ALU operand A select: 00 = PC, 01 = oldPC, 10 = rs1 register
alu_src_b  out  2  ALU operand B select: 00 = rs2 register, 01 = imm, 10 = constant 4
alu_control  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
imm_src  out  2  immediate format: 00 I, 01 S, 10 B, 11 J
result_src  out  2  result select: 00 = ALUOut, 01 = memory data, 10 = ALU result
trap  out  1  sticky error flag

Behaviour:
Reset
- rstn low at a clk edge: state <= FETCH, trap <= 0, watchdog <= 0.
- While rstn = 0, pc_write, ir_write, mem_read, mem_write and reg_write are forced to 0.
- Reset mid-instruction abandons the instruction; no partial writes occur after that edge.

Outputs
- All outputs are Moore decodes of state.
- Exceptions: imm_src is decoded combinationally from op. pc_write in BRANCH depends on the flags.
- Selects not listed for a state are 0.

States
- FETCH: adr_src=0, mem_read=1, alu_src_a=00, alu_src_b=10, add, result_src=10. On mem_ready: ir_write=1, pc_write=1, go to DECODE. Otherwise stay.
- DECODE: alu_src_a=01, alu_src_b=01, add (branch/jump target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other op -> ERROR
- MEMADR: alu_src_a=10, alu_src_b=01, add. Next: MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: adr_src=1, mem_read=1. Go to MEMWB on mem_ready.
- MEMWB: result_src=01, reg_write=1. Go to FETCH.
- MEMWRITE: adr_src=1, mem_write=1. Go to FETCH on mem_ready.
- EXECR: alu_src_a=10, alu_src_b=00, ALUOp=funct. Go to ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, ALUOp=funct. Go to ALUWB.
- ALUWB: result_src=00, reg_write=1. Go to FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, sub, result_src=00. Go to FETCH.
  - pc_write = taken, where taken is: funct3 000 zero; 001 !zero; 100 negative; 101 !negative; otherwise 0 (treated as not-taken, no trap).
- JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1. Go to ALUWB (rd = oldPC+4).
- ERROR: all strobes 0, trap=1. Stays until reset.

ALU decode (funct ALUOp)
- funct3 000: sub if (op[5] & funct7b5), else add.
- funct3 010: slt. funct3 110: or. funct3 111: and.
- Any other funct3: ERROR from EXECR/EXECI on the next edge, with no reg_write.

Watchdog
- Counts consecutive cycles spent in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
- Clears on mem_ready or on state change.
- When the count reaches MEM_TIMEOUT (MEM_TIMEOUT>0), go to ERROR.
- mem_ready=1 in the same cycle as the limit wins (normal transition).

Latency (zero wait states)
- R/I-type: 4 cycles. lw: 5. sw: 4. branch: 3. jal: 4.

Optional Feature:
CTRL_PERF_CNT_EN
- Defined: adds output ports cycle_cnt[31:0] and instret_cnt[31:0].
  - Both cleared on reset.
  - cycle_cnt increments every non-reset cycle except in ERROR.
  - instret_cnt increments on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH.
  - Both wrap at 2^32.
- Undefined: ports and counters are absent.

Decomposition:
- Package ctrl_pkg holds:
  - state_e enum
  - opcode constants: OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL
  - ALU_ADD/SUB/AND/OR/SLT codes
  - src-select and imm-format constants
- Sub-module alu_decoder: combinational (ALUOp, funct3, op[5], funct7b5) -> alu_control plus an illegal flag.

Test Plan:
- add, op=0110011, funct3=000, funct7b5=0, mem_ready tied 1:
  - States FETCH, DECODE, EXECR, ALUWB, FETCH.
  - reg_write=1 for exactly 1 cycle in cycle 4.
  - alu_control=000 in EXECR.
- lw with mem_ready low 3 cycles in MEMREAD:
  - mem_read and adr_src=1 held for 4 cycles.
  - MEMWB with result_src=01; total 8 cycles.
- beq, funct3=000:
  - zero=1: pc_write=1 in cycle 3.
  - zero=0: pc_write=0.
  - blt, funct3=100, negative=1: pc_write=1.
- Illegal opcode op=0000000:
  - Goes DECODE -> ERROR; trap=1 stays set.
  - Strobes stay 0 until rstn=0 for one edge, which returns to FETCH with trap=0.
- MEM_TIMEOUT=16 with mem_ready held 0 in FETCH:
  - ERROR entered after 16 wait cycles.
  - With mem_ready=1 on the 16th cycle: DECODE is entered instead.
- rstn=0 asserted during MEMWRITE:
  - mem_write is 0 that cycle.
  - State is FETCH next cycle.
  - With CTRL_PERF_CNT_EN defined: cycle_cnt=0 and instret_cnt=0.
